// File: rtl/ddr_wr_pkg.sv
// Shared types and constants for the DDR write-burst controller.
package ddr_wr_pkg;

    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_BURST_LEN  = 16;
    localparam int BYTES_PER_BEAT = DEF_DATA_WIDTH / 8;
    localparam int BURST_BYTES    = DEF_BURST_LEN * BYTES_PER_BEAT;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wr_state_t;

endpackage

// File: rtl/ddr_wr_burst_ctrl_skid_buf.sv
// Two-entry FIFO that absorbs the one-cycle FIFO read latency under wready stalls.
module ddr_wr_skid_buf #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             tb_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ddr_wr_burst_ctrl.sv
// Drains write_ddr_fifo into DDR as fixed-length AXI write bursts over a linear frame buffer.
// Optional DDR_WR_PINGPONG_EN alternates frames between two buffers (wr_buf_idx).
module ddr_wr_burst_ctrl
    import ddr_wr_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int LEVEL_WIDTH = 9,
    parameter int ADDR_WIDTH  = 28,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_BEATS = 115200
) (
    input  logic                    clk,
    input  logic                    tb_rst,
    input  logic                    enable,
    input  logic                    frame_sync,
    input  logic [ADDR_WIDTH-1:0]   frame_base,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                    fifo_rd_en,
    input  logic                    fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0]  fifo_rd_water_level,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    frame_done,
`ifdef DDR_WR_PINGPONG_EN
    output logic                    wr_buf_idx,
`endif
    output logic                    busy
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int CW         = $clog2(FRAME_BEATS + 1);

    localparam logic [ADDR_WIDTH-1:0]  BURST_INC = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);
    localparam logic [CW-1:0]          BL_CNT    = CW'(BURST_LEN);
    localparam logic [CW-1:0]          FRAME_END = CW'(FRAME_BEATS);
    localparam logic [LEVEL_WIDTH-1:0] LVL_MIN   = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [8:0]             ISSUE_MAX = 9'(BURST_LEN);
    localparam logic [8:0]             LAST_BEAT = 9'(BURST_LEN - 1);

    wr_state_t             state;
    wr_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [CW-1:0]         frame_cnt;
    logic                  sync_pend;
    logic [8:0]            rd_issued;
    logic [8:0]            beat_cnt;
    logic                  rd_pend;
    logic                  pop;
    logic [1:0]            skid_cnt;
    logic [2:0]            occ;
    logic                  frame_wrap;
    logic [ADDR_WIDTH-1:0] sync_base;
    logic [ADDR_WIDTH-1:0] wrap_base;

    ddr_wr_skid_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk    (clk),
        .tb_rst (tb_rst),
        .push   (rd_pend),
        .pop    (pop),
        .din    (fifo_rd_data),
        .dout   (wdata),
        .count  (skid_cnt)
    );

    assign awaddr     = cur_addr;
    assign awlen      = 8'(BURST_LEN - 1);
    assign wstrb      = '1;
    assign busy       = (state != IDLE);
    assign occ        = {1'b0, skid_cnt} + {2'b0, rd_pend};
    assign frame_wrap = (frame_cnt + BL_CNT) == FRAME_END;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        pop        = 1'b0;
        fifo_rd_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && fifo_rd_water_level >= LVL_MIN) state_nxt = ADDR;
            end
            ADDR: begin
                awvalid = 1'b1;
                if (awready) state_nxt = DATA;
            end
            DATA: begin
                wvalid = (skid_cnt != 2'd0);
                wlast  = wvalid && (beat_cnt == LAST_BEAT);
                pop    = wvalid && wready;
                if (pop && wlast) state_nxt = RESP;
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Room is judged after this cycle's pop, counting the read still in flight.
        if ((state == ADDR || state == DATA) && !fifo_rd_empty &&
            rd_issued < ISSUE_MAX && occ < (3'd2 + {2'b0, pop}))
            fifo_rd_en = 1'b1;
    end

`ifdef DDR_WR_PINGPONG_EN
    localparam logic [ADDR_WIDTH-1:0] FRAME_BYTES = ADDR_WIDTH'(FRAME_BEATS * BEAT_BYTES);
    logic idx_nxt;

    assign idx_nxt   = sync_pend ? wr_buf_idx : ~wr_buf_idx;
    assign sync_base = frame_base + (wr_buf_idx ? FRAME_BYTES : '0);
    assign wrap_base = frame_base + (idx_nxt ? FRAME_BYTES : '0);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst)
            wr_buf_idx <= 1'b0;
        else if (frame_sync)
            wr_buf_idx <= 1'b0;
        else if (state == RESP && bvalid && frame_wrap)
            wr_buf_idx <= idx_nxt;
    end
`else
    assign sync_base = frame_base;
    assign wrap_base = frame_base;
`endif

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            cur_addr   <= '0;
            frame_cnt  <= '0;
            sync_pend  <= 1'b1;
            rd_issued  <= '0;
            beat_cnt   <= '0;
            rd_pend    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_pend    <= fifo_rd_en;
            if (fifo_rd_en) rd_issued <= rd_issued + 9'd1;
            if (pop)        beat_cnt  <= beat_cnt + 9'd1;
            if (state == IDLE) begin
                rd_issued <= '0;
                beat_cnt  <= '0;
                if (sync_pend) begin
                    cur_addr  <= sync_base;
                    frame_cnt <= '0;
                    sync_pend <= 1'b0;
                end
            end
            if (state == RESP && bvalid) begin
                if (frame_wrap) begin
                    frame_done <= 1'b1;
                    cur_addr   <= wrap_base;
                    frame_cnt  <= '0;
                end else begin
                    cur_addr  <= cur_addr + BURST_INC;
                    frame_cnt <= frame_cnt + BL_CNT;
                end
            end
            // A sync arriving mid-burst waits here until the next IDLE.
            if (frame_sync) sync_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Randomized self-checking bench for ddr_wr_burst_ctrl with a transaction-level model.
module tb_ddr_wr_burst_ctrl;

    localparam int DW = 256;
    localparam int LW = 9;
    localparam int AW = 28;
    localparam int BL = 16;
    localparam int FB = 64;
    localparam int BB = BL * DW / 8;
`ifdef DDR_WR_PINGPONG_EN
    localparam logic [AW-1:0] PP_OFF = AW'(FB * DW / 8);
`else
    localparam logic [AW-1:0] PP_OFF = '0;
`endif

    logic            clk = 1'b0;
    logic            tb_rst;
    logic            enable;
    logic            frame_sync;
    logic [AW-1:0]   frame_base;
    logic [DW-1:0]   fifo_rd_data;
    logic            fifo_rd_en;
    logic            fifo_rd_empty;
    logic [LW-1:0]   fifo_rd_water_level;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic            bvalid;
    logic            bready;
    logic            frame_done;
    logic            busy;
`ifdef DDR_WR_PINGPONG_EN
    logic            wr_buf_idx;
`endif

    ddr_wr_burst_ctrl #(
        .DATA_WIDTH  (DW),
        .LEVEL_WIDTH (LW),
        .ADDR_WIDTH  (AW),
        .BURST_LEN   (BL),
        .FRAME_BEATS (FB)
    ) dut (
        .clk                 (clk),
        .tb_rst              (tb_rst),
        .enable              (enable),
        .frame_sync          (frame_sync),
        .frame_base          (frame_base),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .awaddr              (awaddr),
        .awlen               (awlen),
        .awvalid             (awvalid),
        .awready             (awready),
        .wdata               (wdata),
        .wstrb               (wstrb),
        .wlast               (wlast),
        .wvalid              (wvalid),
        .wready              (wready),
        .bvalid              (bvalid),
        .bready              (bready),
        .frame_done          (frame_done),
`ifdef DDR_WR_PINGPONG_EN
        .wr_buf_idx          (wr_buf_idx),
`endif
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int pushed_total = 0;
    int reads_total = 0;
    int beats_total = 0;
    int burst_beat = 0;
    int fd_count = 0;
    int fd_exp_total = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int resp_pend = 0;
    int wmode = 0;

    logic [AW-1:0] m_addr = '0;
    logic [AW-1:0] last_awaddr = '0;
    int  m_cnt = 0;
    bit  m_sync = 1'b1;
    bit  m_idx = 1'b0;
    bit  exp_fd = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] m_base(input bit idx);
        return frame_base + (idx ? PP_OFF : '0);
    endfunction

    // FIFO read side: one-cycle read latency
    initial begin
        bit rd;
        fifo_rd_data = '0;
        fifo_rd_empty = 1'b1;
        fifo_rd_water_level = '0;
        forever begin
            @(negedge clk);
            rd = fifo_rd_en;
            @(posedge clk);
            #1;
            if (rd && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
            #1;
            fifo_rd_empty = (fifo_q.size() == 0);
            fifo_rd_water_level = LW'(fifo_q.size());
        end
    end

    // AXI slave: aw/w ready and write responses
    initial begin
        bit hs_b, lastw;
        awready = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
        forever begin
            @(negedge clk);
            hs_b = bvalid && bready;
            lastw = wvalid && wready && wlast;
            @(posedge clk);
            #1;
            if (lastw) resp_pend++;
            if (hs_b) begin
                bvalid = 1'b0;
                resp_pend--;
            end else if (!bvalid && resp_pend > 0) begin
                bvalid = (wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            unique case (wmode)
                0: wready = 1'b1;
                1: wready = ~wready;
                default: wready = 1'($urandom_range(0, 1));
            endcase
            awready = (wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor and reference model
    initial begin
        int d;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (tb_rst) continue;
            chk("frame_done", frame_done, exp_fd);
            if (frame_done) fd_count++;
            exp_fd = 1'b0;
            if (awvalid && awready) begin
                if (m_sync) begin
                    m_addr = m_base(m_idx);
                    m_cnt = 0;
                    m_sync = 1'b0;
                end
                chk("awaddr", awaddr, m_addr);
                chk("awlen", awlen, BL - 1);
`ifdef DDR_WR_PINGPONG_EN
                chk("wr_buf_idx", wr_buf_idx, m_idx);
`endif
                last_awaddr = awaddr;
            end
            if (fifo_rd_en) begin
                reads_total++;
                chk("rd_when_empty", fifo_rd_empty, 0);
            end
            if (wvalid && wready) begin
                chk("wdata_avail", exp_q.size() != 0, 1);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                chk("wdata", wdata, e);
                chk("wlast", wlast, burst_beat == BL - 1);
                chk("wstrb", wstrb, {(DW/8){1'b1}});
                if (burst_beat == 0) first_cyc = cyc;
                if (burst_beat == BL - 1) last_cyc = cyc;
                burst_beat = (burst_beat + 1) % BL;
                beats_total++;
            end
            if (fifo_rd_en || (wvalid && wready)) begin
                d = reads_total - beats_total;
                chk("skid_occupancy", d >= 0 && d <= 2, 1);
            end
            if (bvalid && bready) begin
                m_cnt += BL;
                m_addr = m_addr + AW'(BB);
                if (m_cnt == FB) begin
                    exp_fd = 1'b1;
                    fd_exp_total++;
                    m_cnt = 0;
                    if (!m_sync) m_idx = ~m_idx;
                    m_addr = m_base(m_idx);
                end
            end
        end
    end

    task automatic push_n(input int n);
        logic [DW-1:0] w;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
            fifo_q.push_back(w);
            exp_q.push_back(w);
            pushed_total++;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        @(negedge clk);
        while ((beats_total != pushed_total || busy || resp_pend != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 3000, 1);
    endtask

    task automatic sync_at_beat(input int b);
        int n = 0;
        while (!(busy && burst_beat >= b) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("sync_wait", n < 1000, 1);
        @(posedge clk);
        #1;
        frame_sync = 1'b1;
        m_sync = 1'b1;
        m_idx = 1'b0;
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, b0, n, fd0;
        bit seen;
        tb_rst = 1'b1;
        enable = 1'b0;
        frame_sync = 1'b0;
        frame_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_awlen", awlen, BL - 1);
        chk("rst_wstrb", wstrb, {(DW/8){1'b1}});
`ifdef DDR_WR_PINGPONG_EN
        chk("rst_buf_idx", wr_buf_idx, 0);
`endif
        @(posedge clk);
        #1;
        tb_rst = 1'b0;
        frame_base = 28'h0100000;
        enable = 1'b1;

        // zero-wait burst
        wmode = 0;
        r0 = reads_total;
        push_n(16);
        wait_drain("t1_drain");
        chk("t1_reads", reads_total - r0, 16);
        chk("t1_span", last_cyc - first_cyc, BL - 1);
        chk("t1_addr", last_awaddr, 28'h0100000);

        // toggling wready
        wmode = 1;
        r0 = reads_total;
        b0 = beats_total;
        push_n(16);
        wait_drain("t2_drain");
        chk("t2_reads", reads_total - r0, 16);
        chk("t2_beats", beats_total - b0, 16);

        // level threshold
        wmode = 0;
        push_n(15);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (awvalid || busy) seen = 1'b1;
        end
        chk("t3_hold", seen, 0);
        push_n(1);
        n = 0;
        @(negedge clk);
        while (!awvalid && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("t3_start", n <= 1, 1);
        wait_drain("t3_drain");

        // frame wrap
        wmode = 2;
        push_n(32);
        wait_drain("t4_drain");
        chk("t4_fd_count", fd_count, 1);
        chk("t4_fifth", last_awaddr, 28'h0100000 + PP_OFF);

        // frame_sync mid-burst
        push_n(16);
        sync_at_beat(5);
        wait_drain("t5_drain_a");
        chk("t5_old_addr", last_awaddr, 28'h0100200 + PP_OFF);
        push_n(16);
        wait_drain("t5_drain_b");
        chk("t5_rebase", last_awaddr, 28'h0100000);
        chk("t5_fd_count", fd_count, 1);

        // enable dropped mid-burst
        push_n(32);
        n = 0;
        while (!(busy && burst_beat >= 3) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_wait", n < 1000, 1);
        enable = 1'b0;
        n = 0;
        while ((busy || resp_pend != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_finish", n < 1000, 1);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (awvalid || busy) seen = 1'b1;
        end
        chk("t6_no_new", seen, 0);
        chk("t6_left", exp_q.size(), 16);
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_drain("t6_drain");

        // sync during the frame-completing burst
        fd0 = fd_count;
        push_n(16);
        sync_at_beat(5);
        wait_drain("t7_drain");
        chk("t7_fd", fd_count - fd0, 1);
        push_n(16);
        wait_drain("t7_drain_b");
        chk("t7_rebase", last_awaddr, 28'h0100000);

        // randomized bursts
        for (int i = 0; i < 12; i++) begin
            wmode = $urandom_range(0, 2);
            push_n(16 * $urandom_range(1, 2));
            if ($urandom_range(0, 2) == 0) sync_at_beat($urandom_range(1, 10));
            wait_drain("rnd_drain");
        end
        chk("fd_total", fd_count, fd_exp_total);
        chk("all_read", reads_total, pushed_total);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
